// File: rtl/cordic_phase_gen_if.sv
// Sample stream from the phase generator to the CORDIC rotator:
// starting vector (x_start, y_start) plus rotation angle under valid/ready.
interface cordic_phase_gen_if #(
  parameter int unsigned XY_W    = 16,
  parameter int unsigned ANGLE_W = 32
);
  logic               out_valid;
  logic               out_ready;
  logic [XY_W-1:0]    x_start;
  logic [XY_W-1:0]    y_start;
  logic [ANGLE_W-1:0] angle;

  modport master (output out_valid, x_start, y_start, angle, input  out_ready);
  modport slave  (input  out_valid, x_start, y_start, angle, output out_ready);
endinterface

// File: rtl/cordic_phase_gen.sv
// Phase accumulator feeding a CORDIC rotator: emits bursts of (amp, 0, phase)
// samples, advancing phase by fcw on every accepted sample.
module cordic_phase_gen #(
  parameter int unsigned XY_W    = 16,
  parameter int unsigned ANGLE_W = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [ANGLE_W-1:0] fcw,
  input  logic [ANGLE_W-1:0] phase_init,
  input  logic [CNT_W-1:0]   burst_len,
  input  logic [XY_W-1:0]    amp,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  cordic_phase_gen_if.master smp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ANGLE_W-1:0] phase;
  logic [ANGLE_W-1:0] phase_nxt;
  logic [ANGLE_W-1:0] fcw_q;
  logic [ANGLE_W-1:0] fcw_nxt;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   len_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [XY_W-1:0]    amp_q;
  logic [XY_W-1:0]    amp_nxt;
  logic               valid_q;
  logic               valid_nxt;
  logic               done_nxt;
  logic               busy_nxt;

  logic               hs_c;
  logic               last_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic [ANGLE_W-1:0] phase_inc_c;

  assign hs_c        = valid_q && smp.out_ready;
  assign cnt_inc_c   = sample_cnt + CNT_W'(1);
  assign phase_inc_c = phase + fcw_q;
  // burst_len == 0 means continuous, so it can never be the last sample
  assign last_c      = (len_q != '0) && (cnt_inc_c == len_q);

  assign smp.out_valid = valid_q;
  assign smp.angle     = phase;
  assign smp.x_start   = amp_q;
  assign smp.y_start   = '0;

  // State register and all datapath/output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= '0;
      fcw_q      <= '0;
      len_q      <= '0;
      amp_q      <= '0;
      sample_cnt <= '0;
      valid_q    <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      fcw_q      <= fcw_nxt;
      len_q      <= len_nxt;
      amp_q      <= amp_nxt;
      sample_cnt <= cnt_nxt;
      valid_q    <= valid_nxt;
      done       <= done_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state and next-register values
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    fcw_nxt   = fcw_q;
    len_nxt   = len_q;
    amp_nxt   = amp_q;
    cnt_nxt   = sample_cnt;
    valid_nxt = valid_q;
    done_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (start) begin
          fcw_nxt   = fcw;
          len_nxt   = burst_len;
          amp_nxt   = amp;
          phase_nxt = phase_init;
          cnt_nxt   = '0;
          valid_nxt = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (hs_c) begin
          phase_nxt = phase_inc_c;
          cnt_nxt   = cnt_inc_c;
          if (last_c || stop) begin
            valid_nxt = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end else if (stop) begin
          // pending sample stays valid until the rotator takes it
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (hs_c) begin
          phase_nxt = phase_inc_c;
          cnt_nxt   = cnt_inc_c;
          valid_nxt = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: doc/cordic_phase_gen.md
CORDIC_PHASE_GEN -- requirements
Module: cordic_phase_gen

Interface
REQ-001 Parameter: XY_W, 16, width of x_start/y_start and amp.
REQ-002 Parameter: ANGLE_W, 32, signed angle width; 2^(ANGLE_W-1) represents pi.
REQ-003 Parameter: CNT_W, 16, width of burst_len and sample_cnt.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  begin burst; sampled only in IDLE.
REQ-008 stop  input  1  abort burst; sampled only in RUN.
REQ-009 fcw  input  ANGLE_W  phase increment per accepted sample, captured at start.
REQ-010 phase_init  input  ANGLE_W  first angle, captured at start.
REQ-011 burst_len  input  CNT_W  samples per burst, captured at start; 0 = continuous.
REQ-012 amp  input  XY_W  signed magnitude, captured at start.
REQ-013 out_valid  output  1  sample available to the rotator.
REQ-014 out_ready  input  1  rotator accepts (its in_ready).
REQ-015 x_start  output  XY_W  equals captured amp.
REQ-016 y_start  output  XY_W  constant zero.
REQ-017 angle  output  ANGLE_W  current phase.
REQ-018 busy  output  1  high in RUN or STOP.
REQ-019 done  output  1  one-cycle pulse at burst completion or abort.
REQ-020 sample_cnt  output  CNT_W  handshakes completed in the current burst.

Function
REQ-021 FSM states: IDLE, RUN, STOP.
REQ-022 IDLE: out_valid=0. start=1 captures all four inputs, sets phase=phase_init, clears sample_cnt, and moves to RUN. out_valid SHALL be 1 on the next cycle (1-cycle latency).
REQ-023 Handshake = out_valid && out_ready. On each handshake, phase SHALL advance by fcw modulo 2^ANGLE_W, wrapping with no saturation, and sample_cnt SHALL increment.
REQ-024 While out_valid=1 and out_ready=0, angle, x_start, y_start and out_valid SHALL hold unchanged. Once asserted, out_valid SHALL NOT drop without a handshake.
REQ-025 RUN with burst_len!=0: the handshake that makes sample_cnt equal burst_len SHALL move the FSM to IDLE. out_valid=0 and done=1 on the following cycle.
REQ-026 RUN with burst_len=0: the burst runs until stop. sample_cnt wraps modulo 2^CNT_W.
REQ-027 stop=1 in RUN with a handshake in the same cycle: go to IDLE and emit no further sample. Pulse done on the next cycle.
REQ-028 stop=1 in RUN with no handshake: go to STOP and keep the pending sample valid. The STOP handshake returns the FSM to IDLE and pulses done. stop=0 SHALL NOT cancel STOP.
REQ-029 In STOP, phase still advances on the handshake. The final sample SHALL NOT be repeated.
REQ-030 start is ignored outside IDLE; stop is ignored outside RUN. start and stop together in IDLE: start wins.
REQ-031 If a burst's final handshake coincides with stop, the FSM goes to IDLE with a single done pulse.
REQ-032 done SHALL NOT assert for any reason other than REQ-025/027/028/031.
REQ-033 sample_cnt SHALL hold its last value in IDLE until the next start.

Reset
REQ-034 rst_n=0 SHALL immediately force: state=IDLE, out_valid=0, busy=0, done=0, angle=0, x_start=0, y_start=0, sample_cnt=0.
REQ-035 Reset mid-burst SHALL discard the burst with no done pulse. After release, out_valid stays 0 until a new start.

Verification
REQ-036 fcw=0x10000000, phase_init=0, burst_len=4, out_ready=1 -> angles 0, 0x10000000, 0x20000000, 0x30000000 on consecutive cycles. done=1 one cycle after the 4th sample; sample_cnt=4.
REQ-037 phase_init=0x70000000, fcw=0x20000000, burst_len=3 -> angles 0x70000000, 0x90000000, 0xB0000000. Wrap occurs with no saturation.
REQ-038 burst_len=2, out_ready low for 3 cycles on the first sample -> angle holds phase_init for 3 cycles and out_valid stays 1. Exactly 2 handshakes occur, then done.
REQ-039 burst_len=0, out_ready=0 at the cycle stop is asserted -> FSM in STOP, same sample held. out_ready=1 -> one handshake, then IDLE with done. Total handshakes = prior count + 1.
REQ-040 rst_n pulsed low after 5 samples of burst_len=10 -> all outputs 0 at once and no done pulse. A new start with phase_init=0x40000000 then yields first angle 0x40000000.
REQ-041 start asserted during RUN and stop asserted during IDLE -> no state change. Angle sequence matches REQ-036.
